// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the time-multiplexed FIR (fir_mac_seq).
// FIR_MAC_SAT_EN selects saturating narrowing; otherwise results wrap.
package fir_mac_pkg;

    localparam int TAPS_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Result is sign-correct in the low data_w bits; the caller truncates.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int data_w);
`ifdef FIR_MAC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - data_w)) >>> (64 - data_w);
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: synchronous write, combinational read by tap index,
// synchronous active-low clear. Out-of-range write addresses are ignored.
module fir_coef_bank
    import fir_mac_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int TAPS   = 6,
    localparam int KW    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [KW-1:0]            waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic [KW-1:0]            raddr,
    output logic signed [COEF_W-1:0] rdata
);

    logic signed [COEF_W-1:0] mem [TAPS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
        end else if (we && (32'(waddr) < TAPS)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one signed MAC walks the coefficient bank, one tap per cycle.
// Define FIR_MAC_SAT_EN for saturating output narrowing (default build wraps).
module fir_mac_seq
    import fir_mac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 6,
    parameter int OUT_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      busy
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int KW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [KW-1:0]            k;
    logic signed [COEF_W-1:0] c_k;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  acc_sh;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_coef_bank (
        .clk   (clk),
        .reset (reset),
        .we    (coef_we && (state == IDLE)),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (k),
        .rdata (c_k)
    );

    assign prod     = PW'(x[k]) * PW'(c_k);
    assign acc_nxt  = acc + ACC_W'(prod);
    assign acc_sh   = acc_nxt >>> OUT_SHIFT;
    assign in_ready = reset && (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
                        x[0]  <= in_data;
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + 1'b1;
                    // Final tap: the result is captured from acc_nxt so it includes this product.
                    if (k == K_LAST) begin
                        k         <= '0;
                        out_data  <= DATA_W'(narrow(64'(acc_sh), DATA_W));
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed, table-driven bench for fir_mac_seq with coefficients {1,2,3,3,2,1}.
module tb_fir_mac_seq;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 6;
    localparam int KW     = 3;
`ifdef FIR_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic coef_we = 1'b0;
    logic [KW-1:0] coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    fir_mac_seq #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .OUT_SHIFT (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [7:0] d;
        int                wmode;   // 0 none, 1 coef write while busy, 2 coef write with accept
        int                hold;    // cycles of out_ready=0 while in OUT
        int                exp;
    } vec_t;

    vec_t tv[$];

    function automatic int sel(input int wrap_v, input int sat_v);
        return SAT ? sat_v : wrap_v;
    endfunction

    function automatic void add(input int d, input int w, input int h, input int e);
        vec_t v;
        v.d = 8'(d);
        v.wmode = w;
        v.hold = h;
        v.exp = e;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = KW'(a);
        coef_data = COEF_W'(v);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the result is taken.
    task automatic do_sample(input vec_t v, input string tag, output int got, output int acc_cyc);
        int guard;
        int lat;
        guard = 0;
        lat = 1;
        got = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk($sformatf("%s in_ready_timeout", tag), 0, 1);
        in_data  = v.d;
        in_valid = 1'b1;
        if (v.wmode == 2) begin
            coef_we = 1'b1; coef_addr = 3'd2; coef_data = -8'sd3;
        end
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk($sformatf("%s busy", tag), int'(busy), 1);
        chk($sformatf("%s in_ready_low", tag), int'(in_ready), 0);
        if (v.wmode == 1) begin
            coef_we = 1'b1; coef_addr = 3'd2; coef_data = -8'sd3;
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, TAPS + 1);
        got = int'(out_data);
        if (out_valid) begin
            for (int h = 0; h < v.hold; h++) begin
                in_valid = 1'b1;
                in_data  = 8'sd55;
                @(negedge clk);
                chk($sformatf("%s hold%0d data", tag, h), int'(out_data), got);
                chk($sformatf("%s hold%0d valid", tag, h), int'(out_valid), 1);
                chk($sformatf("%s hold%0d in_ready", tag, h), int'(in_ready), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("%s valid_drop", tag), int'(out_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got;
        int ac;
        int prev_ac;
        int prev_hold;
        int seen;
        int coefs [TAPS] = '{1, 2, 3, 3, 2, 1};

        // Impulse
        add(1, 0, 0, 1); add(0, 0, 0, 2); add(0, 0, 0, 3);
        add(0, 0, 0, 3); add(0, 0, 0, 2); add(0, 0, 0, 1);
        // Step
        add(10, 0, 0, 10); add(10, 0, 0, 30); add(10, 0, 0, 60); add(10, 0, 0, 90);
        add(10, 0, 0, 110); add(10, 0, 0, 120); add(10, 0, 0, 120);
        // Positive overflow
        add(100, 0, 0, sel(-46, 127)); add(100, 0, 0, sel(-122, 127));
        add(100, 0, 0, sel(-108, 127)); add(100, 0, 0, sel(-94, 127));
        add(100, 0, 0, sel(86, 127)); add(100, 0, 0, sel(-80, 127));
        // Negative overflow
        add(-100, 0, 0, sel(-24, 127)); add(-100, 0, 0, sel(88, 127));
        add(-100, 0, 0, 0); add(-100, 0, 0, sel(-88, -128));
        add(-100, 0, 0, sel(24, -128)); add(-100, 0, 0, sel(80, -128));
        // Backpressure, then a coefficient write while busy, then flush
        add(0, 0, 5, sel(-76, -128));
        add(0, 1, 0, sel(124, -128));
        add(0, 0, 0, sel(-88, -128)); add(0, 0, 0, sel(-44, -128));
        add(0, 0, 0, -100); add(0, 0, 0, 0);
        // c[2] must be unchanged after the busy write
        add(1, 0, 0, 1); add(0, 0, 0, 2); add(0, 0, 0, 3);
        add(0, 0, 0, 3); add(0, 0, 0, 2); add(0, 0, 0, 1);
        // Write c[2]=-3 in the same cycle as the impulse accept
        add(1, 2, 0, 1); add(0, 0, 0, 2); add(0, 0, 0, -3);
        add(0, 0, 0, 3); add(0, 0, 0, 2); add(0, 0, 0, 1);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(in_ready), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst out_data", int'(out_data), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("release in_ready", int'(in_ready), 1);

        for (int i = 0; i < TAPS; i++) write_coef(i, coefs[i]);
        write_coef(6, 99);
        write_coef(7, -99);

        prev_ac = 0;
        prev_hold = 0;
        for (int i = 0; i < tv.size(); i++) begin
            do_sample(tv[i], $sformatf("vec%0d", i), got, ac);
            chk($sformatf("vec%0d out_data", i), got, tv[i].exp);
            if (i > 0) chk($sformatf("vec%0d spacing", i), ac - prev_ac, TAPS + 2 + prev_hold);
            prev_ac = ac;
            prev_hold = tv[i].hold;
        end

        // Reset during the third MAC cycle
        in_data  = 8'sd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midmac in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("midmac busy", int'(busy), 0);
        chk("midmac out_valid", int'(out_valid), 0);
        chk("midmac out_data", int'(out_data), 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midmac no_output", seen, 0);
        chk("midmac in_ready_back", int'(in_ready), 1);

        for (int i = 0; i < TAPS; i++) begin
            vec_t v;
            v.d = (i == 0) ? 8'sd1 : 8'sd0;
            v.wmode = 0;
            v.hold = 0;
            v.exp = 0;
            do_sample(v, $sformatf("post_rst%0d", i), got, ac);
            chk($sformatf("post_rst%0d out_data", i), got, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, time-multiplexed FIR filter: one signed multiply-accumulate unit iterates over a programmable coefficient bank, one tap per cycle. It succeeds the fixed 5-delay, 8-bit, hard-wired-coefficient FIR in the lab datapath. It adds:
- generic data width, coefficient width and tap count
- runtime coefficient loading
- valid/ready handshakes on both streams

## Interface
- DATA_W, 8, signed sample and result width
- COEF_W, 8, signed coefficient width
- TAPS, 6, number of taps (2..16); delay line holds TAPS samples including the newest
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before narrowing (0..ACC_W-DATA_W)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  signed sample
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  signed filtered result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_data  in  COEF_W  signed coefficient
- busy  out  1  high in MAC or OUT state

## Operation
- Accumulator width: ACC_W = DATA_W + COEF_W + $clog2(TAPS). Products are full precision and signed, and are sign-extended into acc.
- FSM, three states:
  - IDLE: in_ready=1.
    - in_valid & in_ready shifts the delay line: x[0] <= in_data, x[k] <= x[k-1].
    - The same handshake clears acc, sets k=0 and moves to MAC.
  - MAC: acc += x[k]*c[k] and k++ every cycle. After k=TAPS-1 the next state is OUT.
  - OUT: out_valid=1 and out_data is held stable. out_ready=1 moves to IDLE.
- Result: out_data = narrow(acc >>> OUT_SHIFT). Narrowing is low DATA_W bits, two's-complement wrap, unless FIR_MAC_SAT_EN is defined.
- Coefficient writes:
  - Honoured only while busy=0 (IDLE). They are silently dropped while busy.
  - A coef_addr >= TAPS is dropped.
  - A write in the same cycle as an input accept is applied before the MAC reads it, so the new coefficient is used for that sample.
- Reset (reset=0 at a clock edge), including mid-MAC or mid-OUT: the in-flight sample is discarded, no output is produced, and every item below is cleared:
  - state -> IDLE
  - delay line -> 0
  - all coefficients -> 0
  - acc -> 0
  - k -> 0
  - out_valid -> 0
  - out_data -> 0
  - in_ready -> 0 while reset is asserted
  - busy -> 0

## Timing
- An input accepted at edge T gives MAC cycles T+1..T+TAPS. out_valid rises after edge T+TAPS and is visible in cycle T+TAPS+1.
- Maximum throughput is one sample per TAPS+2 cycles, with out_ready held high.
- in_ready is combinational from state and reset only; it never depends on in_valid.
- out_valid stays high and out_data stays constant until out_ready is sampled high. No result is ever dropped.
- in_ready=0 throughout MAC and OUT, so there is no overlap between samples.
- coef_we has no effect on the current cycle's outputs.

## Configuration
- FIR_MAC_SAT_EN defined: narrowing saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_MAC_SAT_EN undefined: narrowing wraps by truncation, matching the previous FIR generation bit-for-bit when the coefficients match.
- Accumulator width and latency are identical in both builds.

## Structure
- Package fir_mac_pkg holds:
  - the state enum (IDLE, MAC, OUT)
  - the acc_w(DATA_W, COEF_W, TAPS) constant function
  - the narrow function (saturate or wrap, selected by the macro)
  - TAPS_MAX=16
- Sub-module fir_coef_bank: a TAPS x COEF_W register file with a synchronous write port, a combinational read port indexed by k, and synchronous active-low clear.

## Test plan
All scenarios use defaults (DATA_W=8, COEF_W=8, TAPS=6) with coefficients loaded as {1,2,3,3,2,1}.
- Impulse: in_data=1, then five zeros, out_ready=1. Outputs are 1,2,3,3,2,1. Each out_valid appears 7 cycles after its accept, and accepts are spaced 8 cycles apart.
- Step: in_data=10 repeated. Outputs are 10,30,60,90,110,120,120.
- Overflow: in_data=100 repeated until steady state. Wrap build gives -80 (1200 mod 256). FIR_MAC_SAT_EN build gives 127. The same test with in_data=-100 gives 80 (wrap) or -128 (saturate).
- Backpressure: out_ready=0 for 5 cycles in OUT. out_data stays constant, in_ready=0, and in_valid is ignored. The result is delivered once on the first out_ready=1.
- Coefficient protection: coef_we with addr=2, data=-3 while busy leaves c[2] unchanged. The same write in IDLE plus a simultaneous impulse=1 gives outputs 1,2,-3,3,2,1.
- Reset mid-MAC: reset=0 at MAC cycle 3. No out_valid follows. After release, an impulse=1 produces all-zero outputs because the coefficients were cleared.
